// File: rtl/fetch_unit.sv
// fetch_unit: PC and fetch sequencer with Start/Done handshake for the 9-bit core.
// Define RELATIVE_BRANCH_EN to treat Target as a signed PC-relative offset.
module fetch_unit #(
  parameter int PC_W = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [8:0] HALT_CODE = 9'h1FF,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instruction,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t r_state, w_state_nx;
  logic [PC_W-1:0] r_pc, w_pc_nx, w_br_pc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic r_done, w_done_nx;
`ifdef RELATIVE_BRANCH_EN
  assign w_br_pc = r_pc + Target;
`else
  assign w_br_pc = Target;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = r_pc;
    w_cnt_nx = r_cnt;
    w_done_nx = r_done;
    if (Start) begin
      w_state_nx = IDLE;
      w_pc_nx = START_ADDR;
      w_cnt_nx = '0;
      w_done_nx = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nx = RUN;
          w_pc_nx = START_ADDR;
        end
        RUN: begin
          // counter saturates rather than wrapping
          w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          if (Instruction == HALT_CODE) begin
            w_state_nx = HALT;
            w_done_nx = 1'b1;
          end else begin
            w_pc_nx = (BranchEn && Taken) ? w_br_pc : r_pc + PC_W'(1);
          end
        end
        HALT: ;
        default: begin
          w_state_nx = IDLE;
          w_pc_nx = START_ADDR;
          w_cnt_nx = '0;
          w_done_nx = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc <= START_ADDR;
      r_cnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      r_cnt <= w_cnt_nx;
      r_done <= w_done_nx;
    end
  end
  assign PC = r_pc;
  assign Running = (r_state == RUN);
  assign Done = r_done;
  assign CycleCnt = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a spec-level model.
module tb_fetch_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start, BranchEn, Taken;
  logic [8:0] Instruction;
  logic [9:0] Target, PC, PC4;
  logic Running, Done, Running4, Done4;
  logic [15:0] CycleCnt;
  logic [3:0] CycleCnt4;
  logic [8:0] rom [1024];
  int m_st, m_pc, m_cnt;
  int n_chk = 0;
  int n_pass = 0;

  fetch_unit dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .PC(PC), .Running(Running),
    .Done(Done), .CycleCnt(CycleCnt));
  fetch_unit #(.CNT_W(4)) dut4 (.Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(rom[PC4]),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .PC(PC4), .Running(Running4),
    .Done(Done4), .CycleCnt(CycleCnt4));

  always #5 Clk = ~Clk;
  always_comb Instruction = rom[PC];

  function automatic int br_dest(int pc, int tgt);
`ifdef RELATIVE_BRANCH_EN
    return (pc + tgt) & 1023;
`else
    return tgt;
`endif
  endfunction

  function automatic int tgt_for(int dest, int pc);
`ifdef RELATIVE_BRANCH_EN
    return (dest - pc) & 1023;
`else
    return dest;
`endif
  endfunction

  task automatic step();
    if (Reset || Start) begin
      m_st = 0; m_pc = 0; m_cnt = 0;
    end else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      m_cnt++;
      if (rom[m_pc] == 9'h1FF) m_st = 2;
      else if (BranchEn && Taken) m_pc = br_dest(m_pc, int'(Target));
      else m_pc = (m_pc + 1) & 1023;
    end
    @(posedge Clk); #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
  endtask

  task automatic launch();
    BranchEn = 0; Taken = 0; Target = 0;
    Start = 1; step(); step();
    Start = 0; step();
  endtask

  task automatic goto_pc(int dest);
    BranchEn = 1; Taken = 1; Target = 10'(tgt_for(dest, int'(PC)));
    step();
    BranchEn = 0; Taken = 0;
  endtask

  task automatic test_reset();
    fill_rom();
    Start = 0; BranchEn = 0; Taken = 0; Target = 0;
    #1 Reset = 1;
    #2;
    n_chk++; if (PC !== 10'd0) $display("FAIL reset_pc got %0d want 0", PC); else n_pass++;
    n_chk++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else n_pass++;
    n_chk++; if (Running !== 1'b0) $display("FAIL reset_running got %b want 0", Running); else n_pass++;
    n_chk++; if (CycleCnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", CycleCnt); else n_pass++;
    @(posedge Clk); #1 Reset = 0;
    m_st = 0; m_pc = 0; m_cnt = 0;
    launch();
    step(); step(); step();
    n_chk++; if (PC !== 10'd3) $display("FAIL prereset_pc got %0d want 3", PC); else n_pass++;
    #2 Reset = 1;
    #1;
    n_chk++; if (PC !== 10'd0) $display("FAIL midrun_reset_pc got %0d want 0", PC); else n_pass++;
    n_chk++; if (Running !== 1'b0) $display("FAIL midrun_reset_running got %b want 0", Running); else n_pass++;
    n_chk++; if (CycleCnt !== 16'd0) $display("FAIL midrun_reset_cnt got %0d want 0", CycleCnt); else n_pass++;
    @(posedge Clk); #1 Reset = 0;
    m_st = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic test_launch();
    fill_rom();
    rom[4] = 9'h1FF;
    launch();
    n_chk++; if (PC !== 10'd0 || Running !== 1'b1) $display("FAIL launch_pc0 got pc=%0d run=%b want pc=0 run=1", PC, Running); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_chk++; if (PC !== 10'(i)) $display("FAIL launch_seq got %0d want %0d", PC, i); else n_pass++;
    end
    n_chk++; if (Done !== 1'b0) $display("FAIL launch_done_early got %b want 0", Done); else n_pass++;
    step();
    n_chk++; if (Done !== 1'b1) $display("FAIL launch_done got %b want 1", Done); else n_pass++;
    n_chk++; if (CycleCnt !== 16'd5) $display("FAIL launch_cnt got %0d want 5", CycleCnt); else n_pass++;
    n_chk++; if (Running !== 1'b0) $display("FAIL launch_running got %b want 0", Running); else n_pass++;
    step(); step();
    n_chk++; if (PC !== 10'd4 || Done !== 1'b1 || CycleCnt !== 16'd5)
      $display("FAIL halt_hold got pc=%0d done=%b cnt=%0d want pc=4 done=1 cnt=5", PC, Done, CycleCnt);
    else n_pass++;
  endtask

  task automatic test_branch();
    fill_rom();
    launch();
    repeat (5) step();
`ifdef RELATIVE_BRANCH_EN
    BranchEn = 1; Taken = 1; Target = 10'h3FD;
    step();
    n_chk++; if (PC !== 10'd2) $display("FAIL rel_back got %0d want 2", PC); else n_pass++;
    goto_pc(1023);
    BranchEn = 1; Taken = 1; Target = 10'd2;
    step();
    n_chk++; if (PC !== 10'd1) $display("FAIL rel_wrap got %0d want 1", PC); else n_pass++;
    BranchEn = 1; Taken = 1; Target = 10'd0;
    step();
    n_chk++; if (PC !== 10'd1) $display("FAIL rel_self got %0d want 1", PC); else n_pass++;
`else
    BranchEn = 1; Taken = 1; Target = 10'd20;
    step();
    n_chk++; if (PC !== 10'd20) $display("FAIL abs_taken got %0d want 20", PC); else n_pass++;
`endif
    launch();
    repeat (5) step();
    BranchEn = 1; Taken = 0; Target = 10'd20;
    step();
    n_chk++; if (PC !== 10'd6) $display("FAIL not_taken got %0d want 6", PC); else n_pass++;
    BranchEn = 0; Taken = 1;
    step();
    n_chk++; if (PC !== 10'd7) $display("FAIL no_branch_en got %0d want 7", PC); else n_pass++;
    Taken = 0;
  endtask

  task automatic test_wrap();
    fill_rom();
    launch();
    goto_pc(1022);
    n_chk++; if (PC !== 10'd1022) $display("FAIL wrap_start got %0d want 1022", PC); else n_pass++;
    step();
    n_chk++; if (PC !== 10'd1023) $display("FAIL wrap_max got %0d want 1023", PC); else n_pass++;
    step();
    n_chk++; if (PC !== 10'd0 || Done !== 1'b0) $display("FAIL wrap_zero got pc=%0d done=%b want pc=0 done=0", PC, Done); else n_pass++;
  endtask

  task automatic test_halt_priority();
    fill_rom();
    rom[9] = 9'h1FF;
    launch();
    goto_pc(9);
    BranchEn = 1; Taken = 1; Target = 10'(tgt_for(30, 9));
    step();
    n_chk++; if (PC !== 10'd9 || Done !== 1'b1) $display("FAIL halt_prio got pc=%0d done=%b want pc=9 done=1", PC, Done); else n_pass++;
    step();
    n_chk++; if (PC !== 10'd9) $display("FAIL halt_ignore_branch got %0d want 9", PC); else n_pass++;
    BranchEn = 0; Taken = 0;
  endtask

  task automatic test_restart();
    fill_rom();
    launch();
    goto_pc(7);
    n_chk++; if (PC !== 10'd7 || Running !== 1'b1) $display("FAIL restart_pre got pc=%0d run=%b want 7 1", PC, Running); else n_pass++;
    Start = 1;
    step();
    n_chk++; if (PC !== 10'd0 || CycleCnt !== 16'd0 || Running !== 1'b0 || Done !== 1'b0)
      $display("FAIL restart got pc=%0d cnt=%0d run=%b done=%b want 0 0 0 0", PC, CycleCnt, Running, Done);
    else n_pass++;
    Start = 0;
  endtask

  task automatic test_saturation();
    fill_rom();
    launch();
    repeat (20) step();
    n_chk++; if (CycleCnt4 !== 4'd15) $display("FAIL sat4 got %0d want 15", CycleCnt4); else n_pass++;
    n_chk++; if (CycleCnt !== 16'd20) $display("FAIL cnt16 got %0d want 20", CycleCnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 24) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    launch();
    m_st = 1; m_pc = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      Start = ($urandom_range(0, 39) == 0);
      BranchEn = 1'($urandom);
      Taken = 1'($urandom);
      Target = 10'($urandom);
      step();
      n_chk++;
      if (PC !== 10'(m_pc) || Done !== (m_st == 2) || Running !== (m_st == 1) ||
          CycleCnt !== 16'((m_cnt > 65535) ? 65535 : m_cnt) || CycleCnt4 !== 4'((m_cnt > 15) ? 15 : m_cnt))
        $display("FAIL random_c%0d got pc=%0d done=%b run=%b cnt=%0d cnt4=%0d want pc=%0d st=%0d cnt=%0d",
          c, PC, Done, Running, CycleCnt, CycleCnt4, m_pc, m_st, m_cnt);
      else n_pass++;
    end
    Start = 0;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_branch();
    test_wrap();
    test_halt_priority();
    test_restart();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
